// File: rtl/uart_tx_periph_pkg.sv
// rtl/uart_tx_periph_pkg.sv - shared UART register map, UART_CON bit positions and TX FSM encoding
package uart_tx_periph_pkg;

  localparam logic [31:0] ADDR_TXD = 32'h4000_0018;
  localparam logic [31:0] ADDR_CON = 32'h4000_0020;

  localparam int CON_BUSY     = 0;
  localparam int CON_OVR      = 1;
  localparam int CON_DONE     = 2;
  localparam int CON_RX_READY = 3;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

  // Transmit-side contribution to UART_CON; bit 3 belongs to the receiver.
  function automatic logic [31:0] con_word(input logic done_f, input logic ovr_f,
                                           input logic busy_f);
    logic [31:0] w;
    w               = '0;
    w[CON_BUSY]     = busy_f;
    w[CON_OVR]      = ovr_f;
    w[CON_DONE]     = done_f;
    w[CON_RX_READY] = 1'b0;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_periph_baud_tick_gen.sv
// rtl/uart_tx_periph_baud_tick_gen.sv - bit-period counter with one-cycle tick at terminal count
module baud_tick_gen #(
  parameter int DIVISOR = 10416
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIVISOR - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with one-entry hold register
module uart_tx_periph
  import uart_tx_periph_pkg::*;
#(
  parameter int DIVISOR = 10416
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        wr_en,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  output logic [31:0] rdata,
  output logic        uart_tx,
  output logic        tx_irq
);

  tx_state_e   state, state_n;
  logic [7:0]  shift, shift_n;
  logic [7:0]  hold, hold_n;
  logic [7:0]  last, last_n;
  logic        hold_v, hold_v_n;
  logic        done, done_n;
  logic        ovr, ovr_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic        tx_n;
  logic        tick;
  logic        frame_start;
  logic        handoff;
  logic        wr_txd, rd_con, wr_direct;
  logic        busy;
  logic        unused_wdata;

  assign wr_txd       = wr_en && (addr == ADDR_TXD);
  assign rd_con       = rd_en && (addr == ADDR_CON);
  assign wr_direct    = wr_txd && (state == TX_IDLE) && !hold_v;
  assign busy         = (state != TX_IDLE) || hold_v;
  assign tx_irq       = done;
  assign unused_wdata = ^wdata[31:8];

  baud_tick_gen #(.DIVISOR(DIVISOR)) u_baud (
    .clk   (clk),
    .reset (reset),
    .clear (frame_start),
    .en    (state != TX_IDLE),
    .tick  (tick)
  );

  always_comb begin
    state_n     = state;
    shift_n     = shift;
    hold_n      = hold;
    hold_v_n    = hold_v;
    last_n      = last;
    done_n      = done;
    ovr_n       = ovr;
    bit_idx_n   = bit_idx;
    frame_start = 1'b0;
    handoff     = 1'b0;

    // Clear first so that any set event below takes precedence.
    if (rd_con) begin
      done_n = 1'b0;
      ovr_n  = 1'b0;
    end

    case (state)
      TX_IDLE: begin
        if (hold_v) begin
          handoff = 1'b1;
        end else if (wr_direct) begin
          shift_n     = wdata[7:0];
          last_n      = wdata[7:0];
          state_n     = TX_START;
          frame_start = 1'b1;
        end
      end
      TX_START: begin
        if (tick) begin
          state_n   = TX_DATA;
          bit_idx_n = 3'd0;
        end
      end
      TX_DATA: begin
        if (tick) begin
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tick) begin
          done_n = 1'b1;
          if (hold_v) handoff = 1'b1;
          else        state_n = TX_IDLE;
        end
      end
      default: state_n = TX_IDLE;
    endcase

    if (handoff) begin
      shift_n     = hold;
      hold_v_n    = 1'b0;
      state_n     = TX_START;
      frame_start = 1'b1;
    end

    // A hold slot being handed off this cycle counts as free.
    if (wr_txd && !wr_direct) begin
      if (!hold_v || handoff) begin
        hold_n   = wdata[7:0];
        last_n   = wdata[7:0];
        hold_v_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end

    case (state_n)
      TX_START: tx_n = 1'b0;
      TX_DATA:  tx_n = shift_n[bit_idx_n];
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= TX_IDLE;
      shift   <= '0;
      hold    <= '0;
      last    <= '0;
      hold_v  <= 1'b0;
      done    <= 1'b0;
      ovr     <= 1'b0;
      bit_idx <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_n;
      shift   <= shift_n;
      hold    <= hold_n;
      last    <= last_n;
      hold_v  <= hold_v_n;
      done    <= done_n;
      ovr     <= ovr_n;
      bit_idx <= bit_idx_n;
      uart_tx <= tx_n;
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == ADDR_TXD) begin
      rdata = {24'b0, last};
    end else if (addr == ADDR_CON) begin
      rdata = con_word(done, ovr, busy);
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - scoreboard bench: serial frame monitor plus register/pin check queue
module tb_uart_tx_periph;
  import uart_tx_periph_pkg::*;

  localparam int D = 4;
  localparam logic [31:0] ADDR_UNMAPPED = 32'h4000_0010;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        wr_en = 1'b0;
  logic [31:0] wdata = '0;
  logic        rd_en = 1'b0;
  logic [31:0] rdata;
  logic        uart_tx;
  logic        tx_irq;

  uart_tx_periph #(.DIVISOR(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wr_en   (wr_en),
    .wdata   (wdata),
    .rd_en   (rd_en),
    .rdata   (rdata),
    .uart_tx (uart_tx),
    .tx_irq  (tx_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         gap;
    bit         aborted;
  } frame_t;

  typedef struct {
    int          sel;
    logic [31:0] val;
    string       name;
  } chk_t;

  frame_t exp_frames[$];
  chk_t   exp_chk[$];
  logic   chk_now = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  // sel: 0 = rdata, 1 = uart_tx, 2 = tx_irq
  task automatic expect_sig(input int sel, input logic [31:0] a, input bit clr,
                            input logic [31:0] v, input string name);
    chk_t c;
    c.sel  = sel;
    c.val  = v;
    c.name = name;
    addr   = a;
    rd_en  = clr;
    exp_chk.push_back(c);
    chk_now = 1'b1;
    step();
    rd_en   = 1'b0;
    chk_now = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] d, input int gap, input bit ab);
    frame_t f;
    f.data    = d;
    f.gap     = gap;
    f.aborted = ab;
    exp_frames.push_back(f);
  endtask

  initial begin : chk_mon
    chk_t c;
    forever begin
      @(negedge clk);
      if (chk_now) begin
        check("check queue nonempty", exp_chk.size() > 0, 1);
        if (exp_chk.size() > 0) begin
          c = exp_chk.pop_front();
          case (c.sel)
            0:       check(c.name, rdata, c.val);
            1:       check(c.name, {31'b0, uart_tx}, c.val);
            default: check(c.name, {31'b0, tx_irq}, c.val);
          endcase
        end
      end
    end
  end

  initial begin : frame_mon
    logic            prev;
    logic [10*D-1:0] smp;
    logic [7:0]      b;
    int              t0;
    int              t_end;
    bit              ok;
    bit              abort;
    frame_t          e;
    prev  = 1'b1;
    t_end = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
      end else if (uart_tx === 1'b0 && prev === 1'b1) begin
        t0    = cyc;
        abort = 1'b0;
        smp   = '1;
        for (int i = 0; i < 10 * D; i++) begin
          if (i > 0) @(negedge clk);
          if (reset) begin
            abort = 1'b1;
            break;
          end
          smp[i] = uart_tx;
        end
        check("frame expected", exp_frames.size() > 0, 1);
        if (exp_frames.size() > 0) e = exp_frames.pop_front();
        else e = '{8'h00, -1, 1'b0};
        if (abort) begin
          check("frame abort expected", 1, {31'b0, e.aborted});
          @(negedge clk);
          check("tx high after reset", {31'b0, uart_tx}, 1);
        end else begin
          ok = (smp[0] === 1'b0) && (smp[9*D] === 1'b1);
          for (int j = 0; j < 10; j++) begin
            for (int k = 0; k < D; k++) begin
              if (smp[j*D+k] !== smp[j*D]) ok = 1'b0;
            end
          end
          for (int j = 0; j < 8; j++) b[j] = smp[(j+1)*D];
          check("frame framing", {31'b0, ok}, 1);
          check("frame not aborted", {31'b0, e.aborted}, 0);
          check("frame data", {24'b0, b}, {24'b0, e.data});
          if (e.gap >= 0) check("frame gap", t0 - t_end, e.gap);
          t_end = t0 + 10 * D;
        end
        prev = 1'b1;
      end else begin
        prev = uart_tx;
      end
    end
  end

  initial begin
    reset = 1'b1;
    step(3);
    reset = 1'b0;
    expect_sig(0, ADDR_CON, 1'b0, 32'h0, "reset con");
    expect_sig(0, ADDR_TXD, 1'b0, 32'h0, "reset txd");
    expect_sig(1, ADDR_CON, 1'b0, 32'h1, "reset uart_tx");
    expect_sig(2, ADDR_CON, 1'b0, 32'h0, "reset tx_irq");

    // single byte
    expect_frame(8'hA5, -1, 1'b0);
    bus_write(ADDR_TXD, 32'hA5);
    step(39);
    expect_sig(0, ADDR_CON, 1'b0, 32'h1, "single busy last stop cycle");
    expect_sig(2, ADDR_CON, 1'b0, 32'h1, "single tx_irq");
    expect_sig(0, ADDR_CON, 1'b1, 32'h4, "single con done");
    expect_sig(0, ADDR_CON, 1'b0, 32'h0, "single con cleared");
    expect_sig(2, ADDR_CON, 1'b0, 32'h0, "single tx_irq cleared");
    expect_sig(0, ADDR_TXD, 1'b0, 32'hA5, "single txd readback");

    // queued byte, back-to-back
    expect_frame(8'h55, -1, 1'b0);
    expect_frame(8'h0F, 0, 1'b0);
    bus_write(ADDR_TXD, 32'h55);
    step(1);
    bus_write(ADDR_TXD, 32'h0F);
    expect_sig(0, ADDR_CON, 1'b0, 32'h1, "queued busy no ovr");
    step(76);
    expect_sig(0, ADDR_CON, 1'b0, 32'h5, "queued busy at cycle 79");
    expect_sig(0, ADDR_CON, 1'b1, 32'h4, "queued idle at cycle 80");

    // overrun, then clear/set collision
    expect_frame(8'h11, -1, 1'b0);
    expect_frame(8'h22, 0, 1'b0);
    bus_write(ADDR_TXD, 32'h11);
    bus_write(ADDR_TXD, 32'h22);
    bus_write(ADDR_TXD, 32'h33);
    expect_sig(0, ADDR_CON, 1'b0, 32'h3, "overrun flag");
    expect_sig(0, ADDR_TXD, 1'b0, 32'h22, "overrun last");
    step(46);
    expect_sig(0, ADDR_CON, 1'b1, 32'h7, "overrun mid second frame");
    step(28);
    expect_sig(0, ADDR_CON, 1'b1, 32'h1, "collision read");
    expect_sig(0, ADDR_CON, 1'b1, 32'h4, "collision set wins");
    expect_sig(0, ADDR_CON, 1'b0, 32'h0, "collision cleared");

    // reset mid-frame during data bit 3, with a queued byte
    expect_frame(8'hC3, -1, 1'b1);
    bus_write(ADDR_TXD, 32'hC3);
    bus_write(ADDR_TXD, 32'h3C);
    step(16);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    expect_sig(0, ADDR_CON, 1'b0, 32'h0, "reset mid-frame con");
    expect_sig(1, ADDR_CON, 1'b0, 32'h1, "reset mid-frame tx idle");

    expect_frame(8'h96, -1, 1'b0);
    bus_write(ADDR_TXD, 32'h96);
    step(40);
    expect_sig(0, ADDR_CON, 1'b1, 32'h4, "fresh frame done");
    expect_sig(0, ADDR_TXD, 1'b0, 32'h96, "fresh txd readback");

    // decode
    bus_write(ADDR_CON, 32'h77);
    bus_write(ADDR_UNMAPPED, 32'h78);
    step(5);
    expect_sig(0, ADDR_CON, 1'b0, 32'h0, "decode no frame");
    expect_sig(0, ADDR_UNMAPPED, 1'b0, 32'h0, "decode unmapped rdata");
    expect_sig(0, ADDR_TXD, 1'b0, 32'h96, "decode last unchanged");
    expect_sig(1, ADDR_CON, 1'b0, 32'h1, "decode tx idle");
    step(50);

    check("frames outstanding", exp_frames.size(), 0);
    check("checks outstanding", exp_chk.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_periph.md
# uart_tx_periph

Memory-mapped UART transmitter peripheral on the CPU data bus. It is the transmit counterpart of the UART receive path that the boot program polls. Software writes a byte to UART_TXD at 0x40000018. The block serialises it as 8N1 on `uart_tx`, with a one-entry holding register so software can queue a second byte. It reports busy, done and overrun flags in bits [2:0] of UART_CON at 0x40000020; the receiver owns bit 3 and the top level ORs the two contributions.

## Interface
- `DIVISOR`, 10416: clock cycles per bit (100 MHz / 9600 baud); legal range ≥ 2.
- `ADDR_TXD`, 32'h40000018: data register address.
- `ADDR_CON`, 32'h40000020: control/status address.
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high.
- `addr` in 32: bus byte address.
- `wr_en` in 1: bus write strobe, qualified by `addr`.
- `wdata` in 32: write data; only [7:0] is used.
- `rd_en` in 1: bus read strobe; used for clear-on-read.
- `rdata` out 32: combinational read data. It is 0 when `addr` matches neither register.
- `uart_tx` out 1: serial line; idles high.
- `tx_irq` out 1: level copy of the done flag.

## Operation
- Registers:
  - `shift[7:0]`: byte on the wire.
  - `hold[7:0]`, `hold_v`: queued byte.
  - `last[7:0]`: last accepted byte.
  - `done`, `ovr`: sticky flags.
  - `baud_cnt`: counts 0..DIVISOR-1.
  - `bit_idx[2:0]`: data bit index.
- FSM states: IDLE, START, DATA, STOP. One bit period is DIVISOR cycles: `baud_cnt` runs 0→DIVISOR-1, and the period ends on the cycle `baud_cnt`==DIVISOR-1.
- IDLE:
  - `uart_tx`=1.
  - A write to ADDR_TXD loads `shift` and `last`, clears `baud_cnt`, and goes to START.
  - If `hold_v` is set, `hold` moves to `shift`, `hold_v` clears, and the FSM goes to START.
- START: `uart_tx`=0 for one bit period, then DATA with `bit_idx`=0.
- DATA:
  - `uart_tx`=`shift[bit_idx]`, LSB first.
  - At the end of each period `bit_idx` increments.
  - After bit 7 the FSM goes to STOP.
- STOP:
  - `uart_tx`=1 for one bit period.
  - At the end of the period `done` is set.
  - If `hold_v` is set, the FSM goes directly to START with `hold`: no idle gap, and the start bit begins on the next cycle. Otherwise it returns to IDLE.
- Writes while not IDLE:
  - If `hold_v`=0: latch into `hold` and `last`, and set `hold_v`.
  - If `hold_v`=1: drop the byte, set `ovr`; `hold` and `last` are unchanged.
- Write in the same cycle STOP hands `hold` to `shift`: the hold slot is considered free that cycle, so the byte is accepted into `hold`.
- Reads:
  - ADDR_TXD returns {24'b0, `last`}.
  - ADDR_CON returns {29'b0, `done`, `ovr`, `busy`}, where `busy` = (state≠IDLE) | `hold_v`.
- Clear-on-read: a cycle with `rd_en` and `addr`==ADDR_CON clears `done` and `ovr` at the clock edge. If a set event coincides with the clearing read, set wins.
- Writes to ADDR_CON are ignored.
- Reset values:
  - state=IDLE, `uart_tx`=1.
  - `shift`=`hold`=`last`=0.
  - `hold_v`=`done`=`ovr`=0.
  - `baud_cnt`=`bit_idx`=0, `tx_irq`=0.
- Reset mid-frame aborts the frame: `uart_tx` returns to 1 on the next cycle and the queued byte is lost.

## Timing
- Write accepted at edge N (IDLE): `uart_tx` falls at cycle N+1.
- Frame length is exactly 10×DIVISOR cycles. `done` is visible in `rdata` the cycle after the last stop-bit cycle.
- Back-to-back frames are separated by zero idle cycles.
- `rdata` is combinational from `addr` and current register state; the bus samples it in the same cycle.
- `uart_tx` is driven from a register, so there are no glitches.

## Structure
- A shared package holds:
  - ADDR_TXD and ADDR_CON.
  - The UART_CON bit positions: BUSY=0, OVR=1, DONE=2, RX_READY=3.
  - The FSM state encoding.
- The receiver block uses the same package.
- One natural sub-module, `baud_tick_gen`: a DIVISOR counter that is cleared on frame start and emits a one-cycle `tick` at terminal count.
- Bus decode stays in the top of this block.

## Test plan
All scenarios use DIVISOR=4.
- Single byte: write 0xA5 from IDLE.
  - `uart_tx` is 0 for 4 cycles, then 1,0,1,0,0,1,0,1 (4 cycles each), then 1.
  - UART_CON reads 0x4 after 40 cycles and reads 0x0 after that read.
- Queued byte: write 0x55 then, two cycles later, 0x0F.
  - The second start bit immediately follows the first stop bit.
  - `busy`=1 for 80 cycles; `ovr`=0.
- Overrun: three writes, 0x11, 0x22, 0x33, in consecutive cycles.
  - Only 0x11 and 0x22 are sent.
  - UART_CON bit1=1; reading UART_TXD returns 0x22.
- Clear/set collision: read UART_CON on the cycle `done` is set → `done` reads 1 afterwards.
- Reset mid-frame: assert `reset` during DATA bit 3 → next cycle `uart_tx`=1 and UART_CON=0x0; a fresh write then transmits normally.
- Decode: write to ADDR_CON and to unmapped 0x40000010 → no frame starts, and `rdata`=0 for the unmapped address.
